axi_wr_arbiter: RTL
===================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameter N_M, default 4: number of managers competing for this subordinate's write path.
REQ-002 Parameter MAX_OUT, default 4: maximum outstanding write bursts (AW accepted, B not yet received).
REQ-003 clk_i  input  1: single clock; all state updates on rising edge.
REQ-004 rst_i  input  1: asynchronous, active-high reset.
REQ-005 aw_req_i  input  N_M: per-manager AWVALID, already address-decoded to this subordinate.
REQ-006 m_awready_o  output  N_M: per-manager AWREADY; at most one bit high.
REQ-007 s_awvalid_o  output  1: AWVALID toward the subordinate.
REQ-008 s_awready_i  input  1: AWREADY from the subordinate.
REQ-009 aw_sel_o  output  $clog2(N_M): AW mux select (granted manager index).
REQ-010 w_sel_o  output  $clog2(N_M): W mux select; valid only while w_active_o=1.
REQ-011 w_active_o  output  1: W channel is open to manager w_sel_o.
REQ-012 w_hs_i  input  1: W handshake (WVALID&WREADY) completed at the subordinate this cycle.
REQ-013 w_last_i  input  1: WLAST of the current W beat.
REQ-014 b_hs_i  input  1: B handshake completed at the subordinate this cycle.
REQ-015 out_cnt_o  output  $clog2(MAX_OUT+1): current outstanding-burst count.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR and DATA.
REQ-017 In IDLE with any aw_req_i bit set and out_cnt_o < MAX_OUT, the FSM SHALL latch the round-robin winner into aw_sel_o and move to ADDR on the next edge.
REQ-018 In IDLE with out_cnt_o == MAX_OUT, the FSM SHALL issue no grant and stay in IDLE.
REQ-019 Round-robin: the search SHALL start at the manager after the last granted one and wrap from N_M-1 to 0.
REQ-020 In ADDR: s_awvalid_o=1; aw_sel_o SHALL be held stable; m_awready_o[aw_sel_o] = s_awready_i; all other m_awready_o bits = 0.
REQ-021 In ADDR, once s_awready_i=1, the FSM SHALL go to DATA, copy aw_sel_o into w_sel_o, and advance the RR pointer past aw_sel_o.
REQ-022 In DATA: w_active_o=1; s_awvalid_o=0; all m_awready_o=0.
REQ-023 DATA SHALL exit to IDLE only on w_hs_i & w_last_i, giving one idle bubble cycle before the next grant.
REQ-024 w_hs_i and w_last_i SHALL be ignored outside DATA.
REQ-025 out_cnt_o SHALL increment by 1 on an AW handshake (ADDR & s_awready_i) and decrement by 1 on b_hs_i.
REQ-026 When both events occur in the same cycle, out_cnt_o SHALL be unchanged.
REQ-027 b_hs_i at out_cnt_o == 0 is a protocol error: the count SHALL saturate at 0; a simulation assertion SHALL fire.
REQ-028 A deasserting aw_req_i bit in ADDR is illegal AXI; the FSM SHALL still hold the grant, and an assertion SHALL fire.

Reset
REQ-029 On rst_i: state=IDLE, RR pointer=0 (manager 0 highest priority), out_cnt_o=0, aw_sel_o=0, w_sel_o=0, s_awvalid_o=0, w_active_o=0, m_awready_o=0.
REQ-030 A reset asserted mid-burst SHALL abandon the burst immediately with no further handshakes; recovery is the system's responsibility.

Structure
REQ-031 N_M, MAX_OUT defaults and the state enum (IDLE/ADDR/DATA) SHALL live in interconnect_pkg.
REQ-032 Winner selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot plus index); one instance per subordinate inside the crossbar.

Verification
REQ-033 Only manager 2 requests; 4-beat burst; s_awready_i=1 -> ADDR one cycle, m_awready_o=0100, w_sel_o=2 for 4 beats, IDLE after WLAST.
REQ-034 All 4 managers request continuously; each completes a 1-beat burst with immediate B -> grant order 0,1,2,3,0.
REQ-035 Issue 4 bursts with no B -> out_cnt_o=4; 5th request gets no grant; one b_hs_i -> count 3, grant proceeds.
REQ-036 AW handshake and b_hs_i in the same cycle at count 2 -> count stays 2.
REQ-037 s_awready_i held low for 5 cycles in ADDR -> s_awvalid_o and aw_sel_o stable for all 5 cycles.
REQ-038 rst_i asserted during beat 2 of a 4-beat burst -> all outputs 0 asynchronously, out_cnt_o=0; first post-reset grant goes to manager 0.

Source files
------------

// File: rtl/interconnect_pkg.sv
// Shared interconnect definitions: default sizing and the write-arbiter state encoding.
package interconnect_pkg;

  localparam int N_M_DEF     = 4;
  localparam int MAX_OUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping at N_M-1.
module rr_arbiter #(
  parameter  int N_M = 4,
  localparam int IW  = $clog2(N_M)
) (
  input  logic [N_M-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [N_M-1:0] gnt_o,
  output logic [IW-1:0]  idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_M; i++) begin
      cand = IW'((int'(ptr_i) + i) % N_M);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// AXI write-path arbiter for one subordinate: RR grant on AW, W routed to the
// granted manager until WLAST, outstanding-burst count bounded by MAX_OUT.
module axi_wr_arbiter
  import interconnect_pkg::*;
#(
  parameter  int N_M     = N_M_DEF,
  parameter  int MAX_OUT = MAX_OUT_DEF,
  localparam int IW      = $clog2(N_M),
  localparam int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N_M-1:0] aw_req_i,
  output logic [N_M-1:0] m_awready_o,
  output logic           s_awvalid_o,
  input  logic           s_awready_i,
  output logic [IW-1:0]  aw_sel_o,
  output logic [IW-1:0]  w_sel_o,
  output logic           w_active_o,
  input  logic           w_hs_i,
  input  logic           w_last_i,
  input  logic           b_hs_i,
  output logic [CW-1:0]  out_cnt_o
);

  wr_state_e      state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  win_idx;
  logic [N_M-1:0] win_oh;
  logic [N_M-1:0] aw_oh;
  logic           can_issue;
  logic           aw_hs;
  logic           b_dec;

  rr_arbiter #(.N_M(N_M)) u_rr (
    .req_i (aw_req_i),
    .ptr_i (rr_ptr),
    .gnt_o (win_oh),
    .idx_o (win_idx)
  );

  assign can_issue = (|aw_req_i) && (out_cnt_o < CW'(MAX_OUT));
  assign aw_hs     = (state == ADDR) && s_awready_i;
  // B at zero count is a protocol error; the count saturates instead of wrapping.
  assign b_dec     = b_hs_i && (out_cnt_o != '0);

  // aw_oh is the registered one-hot twin of aw_sel_o so AWREADY needs no decoder.
  assign m_awready_o = aw_oh & {N_M{s_awvalid_o & s_awready_i}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      aw_sel_o    <= '0;
      aw_oh       <= '0;
      w_sel_o     <= '0;
      s_awvalid_o <= 1'b0;
      w_active_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (can_issue) begin
          state       <= ADDR;
          aw_sel_o    <= win_idx;
          aw_oh       <= win_oh;
          s_awvalid_o <= 1'b1;
        end
        ADDR: if (s_awready_i) begin
          state       <= DATA;
          w_sel_o     <= aw_sel_o;
          rr_ptr      <= (aw_sel_o == IW'(N_M - 1)) ? '0 : aw_sel_o + IW'(1);
          s_awvalid_o <= 1'b0;
          w_active_o  <= 1'b1;
        end
        DATA: if (w_hs_i && w_last_i) begin
          state      <= IDLE;
          w_active_o <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          s_awvalid_o <= 1'b0;
          w_active_o  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_o <= '0;
    end else begin
      case ({aw_hs, b_dec})
        2'b10:   out_cnt_o <= out_cnt_o + CW'(1);
        2'b01:   out_cnt_o <= out_cnt_o - CW'(1);
        default: out_cnt_o <= out_cnt_o;
      endcase
    end
  end

  a_b_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(b_hs_i && (out_cnt_o == '0)));

  a_aw_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state == ADDR) |-> aw_req_i[aw_sel_o]);

endmodule
